// File: rtl/controller_pio_pkg.sv
// controller_pio_pkg: register addresses and edge-type encodings shared by the controller PIOs
package controller_pio_pkg;
  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_DIR     = 2'd1,
    ADDR_IRQMASK = 2'd2,
    ADDR_EDGECAP = 2'd3
  } pio_addr_e;
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;
endpackage

// File: rtl/controller_sync_vec.sv
// controller_sync_vec: WIDTH-bit multi-stage synchronizer for asynchronous inputs
module controller_sync_vec #(
  parameter int WIDTH  = 2,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);
  logic [STAGES-1:0][WIDTH-1:0] r_chain;
  // shift the raw inputs through STAGES flops; the oldest stage is the synchronized value
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_chain <= '0;
    else          r_chain <= {r_chain[STAGES-2:0], i_async};
  assign o_sync = r_chain[STAGES-1];
endmodule

// File: rtl/controller_warn_status_input.sv
// controller_warn_status_input: Avalon-MM input PIO with edge capture and maskable level irq
module controller_warn_status_input
  import controller_pio_pkg::*;
#(
  parameter int               WIDTH       = 2,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = EDGE_RISING,
  parameter logic [WIDTH-1:0] RESET_MASK  = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  localparam logic [2:0] ARM_MAX = 3'(SYNC_STAGES + 1);
  logic [WIDTH-1:0] w_data_in, w_edge, w_w1c;
  logic [WIDTH-1:0] r_prev, r_cap, r_mask;
  logic [2:0]       r_arm;
  logic             w_armed, w_we, w_unused;
  controller_sync_vec #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (in_port),
    .o_sync  (w_data_in)
  );
  assign w_unused = &{1'b0, writedata};
  assign w_armed  = r_arm == ARM_MAX;
  assign w_we     = chipselect && !write_n;
  assign w_w1c    = (w_we && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
  // edges are ignored until the synchronizer has flushed, so lines held high through reset stay quiet
  always_comb
    w_edge = !w_armed                   ? '0 :
             EDGE_TYPE == EDGE_RISING   ? (w_data_in & ~r_prev) :
             EDGE_TYPE == EDGE_FALLING  ? (~w_data_in & r_prev) :
                                          (w_data_in ^ r_prev);
  // arm counter saturates once the sync chain and prev hold post-reset data
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)      r_arm <= '0;
    else if (!w_armed) r_arm <= r_arm + 3'd1;
  // prev tracks data_in one cycle behind for edge detection
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_prev <= '0;
    else          r_prev <= w_data_in;
  // sticky capture bits: W1C clears, but a same-cycle edge wins
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_cap <= '0;
    else          r_cap <= (r_cap & ~w_w1c) | w_edge;
  // irq mask register, written at its own address
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)                              r_mask <= RESET_MASK;
    else if (w_we && address == ADDR_IRQMASK) r_mask <= writedata[WIDTH-1:0];
  assign readdata = address == ADDR_DATA    ? 32'(w_data_in) :
                    address == ADDR_IRQMASK ? 32'(r_mask)    :
                    address == ADDR_EDGECAP ? 32'(r_cap)     : '0;
  assign irq = |(r_cap & r_mask);
endmodule

// File: tb/tb_controller_warn_status_input.sv
// tb_controller_warn_status_input: vector table plus hand sequences checked through an expectation queue
module tb_controller_warn_status_input;
  logic        clk = 0, reset_n = 0, chipselect = 0, write_n = 1;
  logic [1:0]  address = 0, in_port = 0;
  logic [31:0] writedata = 0, rd0, rd2;
  logic        irq0, irq2;
  int          n_cmp = 0, n_bad = 0;
  typedef struct { string name; int kind; logic [31:0] exp; } sb_t;
  typedef struct { logic do_wr; logic [1:0] a; logic [31:0] wd; logic [31:0] exp_rd; logic exp_irq; } vec_t;
  sb_t  q[$];
  vec_t tbl[7];
  always #5 clk = ~clk;
  controller_warn_status_input #(.WIDTH(2), .SYNC_STAGES(2), .EDGE_TYPE(0), .RESET_MASK(2'b00)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd0), .irq(irq0));
  controller_warn_status_input #(.WIDTH(2), .SYNC_STAGES(2), .EDGE_TYPE(2), .RESET_MASK(2'b10)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd2), .irq(irq2));
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(logic [1:0] a, logic [31:0] d);
    address = a; writedata = d; chipselect = 1; write_n = 0;
    @(negedge clk);
    chipselect = 0; write_n = 1;
  endtask
  // kind: 0 = rise readdata, 1 = rise irq, 2 = any readdata, 3 = any irq
  task automatic expect_out(string name, int kind, logic [1:0] a, logic [31:0] e);
    sb_t s;
    logic [31:0] act;
    address = a;
    s.name = name; s.kind = kind; s.exp = e;
    q.push_back(s);
    #1;
    s = q.pop_front();
    act = s.kind == 0 ? rd0 : s.kind == 1 ? {31'b0, irq0} : s.kind == 2 ? rd2 : {31'b0, irq2};
    n_cmp++;
    if (act !== s.exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", s.name, act, s.exp);
    end
  endtask
  initial begin
    tbl[0] = '{1'b0, 2'd0, 32'h0,        32'h3, 1'b0};
    tbl[1] = '{1'b0, 2'd1, 32'h0,        32'h0, 1'b0};
    tbl[2] = '{1'b1, 2'd1, 32'hffffffff, 32'h0, 1'b0};
    tbl[3] = '{1'b1, 2'd0, 32'h0,        32'h3, 1'b0};
    tbl[4] = '{1'b1, 2'd2, 32'hffffffff, 32'h3, 1'b0};
    tbl[5] = '{1'b1, 2'd2, 32'h1,        32'h1, 1'b0};
    tbl[6] = '{1'b0, 2'd3, 32'h0,        32'h0, 1'b0};
    in_port = 2'b11;
    tick(3);
    reset_n = 1;
    tick(10);
    expect_out("held_data",     0, 2'd0, 32'h3);
    expect_out("held_cap",      0, 2'd3, 32'h0);
    expect_out("held_irq",      1, 2'd0, 32'h0);
    expect_out("held_cap_any",  2, 2'd3, 32'h0);
    for (int i = 0; i < 7; i++) begin
      tick(1);
      if (tbl[i].do_wr) wr(tbl[i].a, tbl[i].wd);
      expect_out($sformatf("tbl%0d_rd", i),  0, tbl[i].a, tbl[i].exp_rd);
      expect_out($sformatf("tbl%0d_irq", i), 1, tbl[i].a, 32'(tbl[i].exp_irq));
    end
    in_port = 2'b00;
    tick(5);
    expect_out("fall_no_cap", 0, 2'd3, 32'h0);
    in_port = 2'b01;
    tick(1);
    expect_out("lat_k_data",   0, 2'd0, 32'h0);
    tick(1);
    expect_out("lat_k1_data",  0, 2'd0, 32'h1);
    expect_out("lat_k1_cap",   0, 2'd3, 32'h0);
    expect_out("lat_k1_irq",   1, 2'd3, 32'h0);
    tick(1);
    expect_out("lat_k2_cap",   0, 2'd3, 32'h1);
    expect_out("lat_k2_irq",   1, 2'd3, 32'h1);
    in_port = 2'b11;
    tick(4);
    expect_out("cap11",        0, 2'd3, 32'h3);
    wr(2'd3, 32'h1);
    expect_out("w1c_01",       0, 2'd3, 32'h2);
    expect_out("w1c_irq",      1, 2'd3, 32'h0);
    wr(2'd2, 32'h2);
    expect_out("mask10_irq",   1, 2'd3, 32'h1);
    wr(2'd2, 32'h1);
    in_port = 2'b01;
    tick(4);
    wr(2'd3, 32'h2);
    expect_out("pre_set_clr",  0, 2'd3, 32'h0);
    in_port = 2'b11;
    tick(2);
    wr(2'd3, 32'h2);
    expect_out("set_wins",     0, 2'd3, 32'h2);
    wr(2'd3, 32'h2);
    expect_out("clr_after",    0, 2'd3, 32'h0);
    in_port = 2'b10;
    tick(4);
    in_port = 2'b11;
    tick(4);
    expect_out("pend_cap",     0, 2'd3, 32'h1);
    expect_out("pend_irq",     1, 2'd3, 32'h1);
    wr(2'd2, 32'h0);
    expect_out("mask0_irq",    1, 2'd3, 32'h0);
    expect_out("mask0_cap",    0, 2'd3, 32'h1);
    wr(2'd2, 32'h1);
    expect_out("mask1_irq",    1, 2'd3, 32'h1);
    @(posedge clk);
    #2 reset_n = 0;
    expect_out("rst_irq",      1, 2'd3, 32'h0);
    expect_out("rst_cap",      0, 2'd3, 32'h0);
    expect_out("rst_mask",     0, 2'd2, 32'h0);
    expect_out("rst_mask_any", 2, 2'd2, 32'h2);
    @(negedge clk);
    reset_n = 1;
    tick(10);
    expect_out("any_held",     2, 2'd3, 32'h0);
    in_port = 2'b01;
    tick(4);
    expect_out("any_fall",     2, 2'd3, 32'h2);
    expect_out("any_irq",      3, 2'd3, 32'h1);
    expect_out("rise_fall",    0, 2'd3, 32'h0);
    wr(2'd3, 32'h2);
    expect_out("any_clr",      2, 2'd3, 32'h0);
    in_port = 2'b11;
    tick(4);
    expect_out("any_rise",     2, 2'd3, 32'h2);
    expect_out("rise_rise",    0, 2'd3, 32'h2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
